dram_bank_array: RTL

- Cycle-accurate behavioural model of the DRAM device; sits directly downstream of the DRAM controller.
- Consumes the controller's 2-bit command, one-hot bank/row/column selects and write data.
- Keeps per-bank open-row state with timing checks, and returns read data after a fixed CAS latency.
- Used as the controller's target in system simulation, and is synthesizable for FPGA bring-up.

---
 rtl/dram_bank_array.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dram_bank_array.sv
// Cycle-accurate multi-bank DRAM device model: per-bank open-row FSMs with tRCD/tRP checks, refresh window,
// and a CAS_LAT-deep read pipeline that accepts a read every cycle (no backpressure).
`timescale 1ns/1ps
module dram_bank_array #(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int CAS_LAT      = 2,
  parameter int T_RFC        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cmd,
  input  logic                    rw,
  input  logic                    refresh,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic [DATA_WIDTH-1:0]   dram_data_in,
  output logic [DATA_WIDTH-1:0]   dram_data_out,
  output logic                    data_valid,
  output logic [NUM_OF_BANKS-1:0] bank_open,
  output logic                    busy,
  output logic                    err
);

  localparam int BANK_W    = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int ROW_W     = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int COL_W     = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
  localparam int ROWBUF_W  = NUM_OF_COLS * DATA_WIDTH;
  localparam int MEM_DEPTH = NUM_OF_BANKS * NUM_OF_ROWS;
  localparam int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int T_MAX     = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W     = $clog2(T_MAX + 1);
  localparam int RFC_W     = $clog2(T_RFC + 1);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RW  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVATING,
    S_ACTIVE,
    S_PRECHARGING
  } bank_st_e;

  bank_st_e         st_q  [NUM_OF_BANKS];
  bank_st_e         st_d  [NUM_OF_BANKS];
  logic [CNT_W-1:0] cnt_q [NUM_OF_BANKS];
  logic [CNT_W-1:0] cnt_d [NUM_OF_BANKS];
  logic [ROW_W-1:0] row_q [NUM_OF_BANKS];
  logic [ROW_W-1:0] row_d [NUM_OF_BANKS];
  logic [RFC_W-1:0] rfc_q, rfc_d;
  logic             err_q, err_d;

  logic [ROWBUF_W-1:0] rowbuf_q [NUM_OF_BANKS];
  logic [ROWBUF_W-1:0] mem_q    [MEM_DEPTH];

  logic [CAS_LAT-1:0]    pipe_vld_q;
  logic [DATA_WIDTH-1:0] pipe_dat_q [CAS_LAT];

  logic [BANK_W-1:0]     bidx;
  logic [ROW_W-1:0]      ridx;
  logic [COL_W-1:0]      cidx;
  logic                  bank_hot, row_hot, col_hot;
  logic                  all_idle, rfc_busy;
  logic                  act_go, pre_go, wr_go, rd_go, rfc_go;
  logic [ADDR_W-1:0]     act_addr, pre_addr;
  logic [DATA_WIDTH-1:0] rd_dat;

  assign bank_hot = $onehot(bank_sel);
  assign row_hot  = $onehot(row_sel);
  assign col_hot  = $onehot(col_sel);
  assign rfc_busy = (rfc_q != '0);

  always_comb begin
    bidx = '0;
    ridx = '0;
    cidx = '0;
    for (int b = 0; b < NUM_OF_BANKS; b++) if (bank_sel[b]) bidx = BANK_W'(b);
    for (int r = 0; r < NUM_OF_ROWS; r++)  if (row_sel[r])  ridx = ROW_W'(r);
    for (int c = 0; c < NUM_OF_COLS; c++)  if (col_sel[c])  cidx = COL_W'(c);
  end

  always_comb begin
    all_idle = 1'b1;
    for (int b = 0; b < NUM_OF_BANKS; b++) if (st_q[b] != S_IDLE) all_idle = 1'b0;
  end

  // Refresh wins over cmd; every illegal command is dropped and flagged one cycle later.
  always_comb begin
    err_d  = 1'b0;
    act_go = 1'b0;
    pre_go = 1'b0;
    wr_go  = 1'b0;
    rd_go  = 1'b0;
    rfc_go = 1'b0;
    if (refresh) begin
      if (!all_idle)      err_d  = 1'b1;
      else if (!rfc_busy) rfc_go = 1'b1;
    end else if (cmd != CMD_NOP) begin
      if (rfc_busy || !bank_hot) begin
        err_d = 1'b1;
      end else begin
        case (cmd)
          CMD_ACT: begin
            if (!row_hot || st_q[bidx] != S_IDLE) err_d  = 1'b1;
            else                                  act_go = 1'b1;
          end
          CMD_RW: begin
            if (!col_hot || st_q[bidx] != S_ACTIVE) err_d = 1'b1;
            else if (rw)                            wr_go = 1'b1;
            else                                    rd_go = 1'b1;
          end
          CMD_PRE: begin
            if (st_q[bidx] == S_ACTIVATING || st_q[bidx] == S_PRECHARGING) err_d  = 1'b1;
            else if (st_q[bidx] == S_ACTIVE)                               pre_go = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      st_d[b]  = st_q[b];
      cnt_d[b] = cnt_q[b];
      row_d[b] = row_q[b];
      if (cnt_q[b] != '0) cnt_d[b] = cnt_q[b] - 1'b1;
      case (st_q[b])
        S_ACTIVATING:  if (cnt_q[b] <= CNT_W'(1)) st_d[b] = S_ACTIVE;
        S_PRECHARGING: if (cnt_q[b] <= CNT_W'(1)) st_d[b] = S_IDLE;
        default: ;
      endcase
      if (act_go && bidx == BANK_W'(b)) begin
        st_d[b]  = (T_RCD == 1) ? S_ACTIVE : S_ACTIVATING;
        cnt_d[b] = CNT_W'(T_RCD - 1);
        row_d[b] = ridx;
      end
      if (pre_go && bidx == BANK_W'(b)) begin
        st_d[b]  = (T_RP == 1) ? S_IDLE : S_PRECHARGING;
        cnt_d[b] = CNT_W'(T_RP - 1);
      end
    end
  end

  always_comb begin
    rfc_d = rfc_q;
    if (rfc_go)        rfc_d = RFC_W'(T_RFC);
    else if (rfc_busy) rfc_d = rfc_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        st_q[b]  <= S_IDLE;
        cnt_q[b] <= '0;
        row_q[b] <= '0;
      end
      rfc_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        st_q[b]  <= st_d[b];
        cnt_q[b] <= cnt_d[b];
        row_q[b] <= row_d[b];
      end
      rfc_q <= rfc_d;
      err_q <= err_d;
    end
  end

  assign act_addr = ADDR_W'(bidx) * ADDR_W'(NUM_OF_ROWS) + ADDR_W'(ridx);
  assign pre_addr = ADDR_W'(bidx) * ADDR_W'(NUM_OF_ROWS) + ADDR_W'(row_q[bidx]);
  assign rd_dat   = rowbuf_q[bidx][cidx*DATA_WIDTH +: DATA_WIDTH];

  // Array and row buffers are not reset: the array must survive rst, and a row buffer is
  // only meaningful while its bank is open, so a reset simply abandons it.
  always_ff @(posedge clk) begin
    if (act_go) rowbuf_q[bidx] <= mem_q[act_addr];
    if (wr_go)  rowbuf_q[bidx][cidx*DATA_WIDTH +: DATA_WIDTH] <= dram_data_in;
    if (pre_go) mem_q[pre_addr] <= rowbuf_q[bidx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < CAS_LAT; i++) pipe_dat_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_go;
      if (rd_go) pipe_dat_q[0] <= rd_dat;
      // Stages only move on valid so the last stage holds the previous read between pulses.
      for (int i = 1; i < CAS_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  always_comb begin
    bank_open = '0;
    busy      = rfc_busy;
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      bank_open[b] = (st_q[b] == S_ACTIVE);
      if (st_q[b] == S_ACTIVATING || st_q[b] == S_PRECHARGING) busy = 1'b1;
    end
  end

  assign dram_data_out = pipe_dat_q[CAS_LAT-1];
  assign data_valid    = pipe_vld_q[CAS_LAT-1];
  assign err           = err_q;

endmodule
